// File: rtl/dl_shift_pkg.sv
// Shared definitions for the sequential shifter family: FSM state encoding
// and the operand-width legality check.
package dl_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } dl_shift_state_t;

  // Datapath width must be a power of two, at least 2, so every shift stage is 2**k.
  function automatic bit is_pow2_width(input int width);
    return (width >= 2) && ((width & (width - 1)) == 0);
  endfunction

endpackage

// File: rtl/dl_lshift_stage.sv
// One conditional left-shift stage: shifts by 2**index with zero fill when
// enabled, otherwise passes the data through.
module dl_lshift_stage
  import dl_shift_pkg::*;
#(
  parameter  int NUM_BITS       = 32,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0]       data,
  input  logic [NUM_SHIFT_BITS-1:0] index,
  input  logic                      enable,
  output logic [NUM_BITS-1:0]       result
);

  logic [NUM_SHIFT_BITS:0] amount;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    amount = {{NUM_SHIFT_BITS{1'b0}}, 1'b1} << index;
    result = enable ? (data << amount) : data;
  end

endmodule

// File: rtl/dl_lshift_seq.sv
// Multi-cycle logical left shifter resolving one shamt bit per cycle behind
// valid/ready handshakes. Define DL_LSHIFT_SEQ_EARLY_DONE_EN for early termination.
module dl_lshift_seq
  import dl_shift_pkg::*;
#(
  parameter  int NUM_BITS       = 32,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [NUM_BITS-1:0]       in,
  input  logic [NUM_SHIFT_BITS-1:0] shamt,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [NUM_BITS-1:0]       out
);

  if (!is_pow2_width(NUM_BITS)) begin : g_bad_width
    $error("dl_lshift_seq: NUM_BITS must be a power of two and at least 2");
  end

  localparam logic [NUM_SHIFT_BITS-1:0] LAST_CNT = NUM_SHIFT_BITS'(NUM_SHIFT_BITS - 1);

  dl_shift_state_t             state, state_next;
  logic [NUM_BITS-1:0]         data_reg, data_next;
  logic [NUM_SHIFT_BITS-1:0]   shamt_reg, shamt_next;
  logic [NUM_SHIFT_BITS-1:0]   cnt, cnt_next;

  logic [NUM_SHIFT_BITS-1:0]   cnt_onehot;
  logic                        stage_en;
  logic                        last_stage;
  logic [NUM_BITS-1:0]         stage_result;

  assign cnt_onehot = NUM_SHIFT_BITS'(1) << cnt;
  assign stage_en   = |(shamt_reg & cnt_onehot);

`ifdef DL_LSHIFT_SEQ_EARLY_DONE_EN
  logic [NUM_SHIFT_BITS-1:0] above_mask;
  logic                      bits_above;

  // Finish once no higher shamt bit remains; at the final stage the mask is empty.
  assign above_mask = ~(cnt_onehot | (cnt_onehot - NUM_SHIFT_BITS'(1)));
  assign bits_above = |(shamt_reg & above_mask);
  assign last_stage = !bits_above;
`else
  assign last_stage = (cnt == LAST_CNT);
`endif

  dl_lshift_stage #(
    .NUM_BITS (NUM_BITS)
  ) u_stage (
    .data   (data_reg),
    .index  (cnt),
    .enable (stage_en),
    .result (stage_result)
  );

  always_comb begin
    state_next = state;
    data_next  = data_reg;
    shamt_next = shamt_reg;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (in_val) begin
          data_next  = in;
          shamt_next = shamt;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        data_next = stage_result;
        cnt_next  = cnt + 1'b1;
        if (last_stage) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the simulator runs processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_reg  <= '0;
      shamt_reg <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_next;
      data_reg  <= data_next;
      shamt_reg <= shamt_next;
      cnt       <= cnt_next;
    end
  end

  assign in_rdy  = (state == IDLE);
  assign out_val = (state == DONE);
  assign out     = data_reg;

endmodule

// File: tb/tb_dl_lshift_seq.sv
// Self-checking bench for dl_lshift_seq: a cycle-level reference model compared
// every cycle, plus directed vectors with hand-computed results and latencies.
module tb_dl_lshift_seq;

  localparam int NB = 32;
  localparam int NS = 5;
`ifdef DL_LSHIFT_SEQ_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in;
  logic [NS-1:0] shamt;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out;

  int checks = 0;
  int errors = 0;

  dl_lshift_seq #(.NUM_BITS(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in      (in),
    .shamt   (shamt),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles from the accepting edge to the edge where the result appears.
  function automatic int lat_for(input logic [NS-1:0] s);
    int hi;
    hi = 0;
    for (int i = 0; i < NS; i++) if (s[i]) hi = i;
    return EARLY ? hi + 1 : NS;
  endfunction

  // Reference model: accepted operand, countdown to result, result pending.
  logic          m_pending;
  logic          m_valid;
  int            m_wait;
  logic [NB-1:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_valid   <= 1'b0;
      m_wait    <= 0;
      m_exp     <= '0;
    end else if (m_valid) begin
      if (out_rdy) m_valid <= 1'b0;
    end else if (m_pending) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_pending <= 1'b0;
        m_valid   <= 1'b1;
      end
    end else if (in_val) begin
      m_exp     <= in << shamt;
      m_wait    <= lat_for(shamt);
      m_pending <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_val", out_val, 1'b0);
      check("rst_out", out, 32'h0);
      check("rst_in_rdy", in_rdy, 1'b1);
    end else begin
      check("cyc_in_rdy", in_rdy, !(m_pending || m_valid));
      check("cyc_out_val", out_val, m_valid);
      if (m_valid) check("cyc_out", out, m_exp);
    end
  end

  typedef struct {
    logic [NB-1:0] a;
    logic [NS-1:0] s;
    logic [NB-1:0] y;
    int            lat_full;
    int            lat_early;
    int            stall;
  } vec_t;

  vec_t vecs[7] = '{
    '{32'h0000_0001, 5'd31, 32'h8000_0000, 5, 5, 0},
    '{32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0, 5, 3, 0},
    '{32'h1234_5678, 5'd0,  32'h1234_5678, 5, 1, 0},
    '{32'h0F0F_0F0F, 5'd7,  32'h8787_8780, 5, 3, 10},
    '{32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 5, 5, 0},
    '{32'h0000_00F0, 5'd8,  32'h0000_F000, 5, 4, 0},
    '{32'h8000_0001, 5'd1,  32'h0000_0002, 5, 1, 0}
  };

  task automatic do_op(input logic [NB-1:0] a, input logic [NS-1:0] s,
                       input logic [NB-1:0] y, input int lat, input int stall);
    int n;
    n = 0;
    while (!in_rdy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("pre_in_rdy", in_rdy, 1'b1);
    in_val  = 1'b1;
    in      = a;
    shamt   = s;
    out_rdy = 1'b0;
    @(posedge clk); #1;
    in_val = 1'b0;
    in     = $urandom;
    shamt  = NS'($urandom_range(31, 0));
    n = 0;
    while (!out_val && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, lat);
    check("result", out, y);
    for (int i = 0; i < stall; i++) begin
      in_val = 1'b1;
      in     = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("stall_out", out, y);
      check("stall_out_val", out_val, 1'b1);
      check("stall_in_rdy", in_rdy, 1'b0);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check("post_hs_in_rdy", in_rdy, 1'b1);
    check("post_hs_out_val", out_val, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    in_val  = 1'b0;
    in      = '0;
    shamt   = '0;
    out_rdy = 1'b0;
    #1;
    check("reset_out_val", out_val, 1'b0);
    check("reset_out", out, 32'h0);
    check("reset_in_rdy", in_rdy, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("model_lat_s0", lat_for(5'd0), EARLY ? 1 : 5);
    check("model_lat_s4", lat_for(5'd4), EARLY ? 3 : 5);
    check("model_lat_s31", lat_for(5'd31), 5);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].s, vecs[i].y,
            EARLY ? vecs[i].lat_early : vecs[i].lat_full, vecs[i].stall);

    // Abort an operation mid-flight with an asynchronous reset.
    in_val = 1'b1;
    in     = 32'hFFFF_FFFF;
    shamt  = 5'd1;
    @(posedge clk); #1;
    in_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_val", out_val, 1'b0);
    check("abort_out", out, 32'h0);
    check("abort_in_rdy", in_rdy, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_result", out_val, 1'b0);
    end
    do_op(32'h0000_0003, 5'd2, 32'h0000_000C, EARLY ? 2 : 5, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dl_lshift_seq.md
Name: dl_lshift_seq

Overview:
Multi-cycle logical left shifter, the left-direction counterpart of the library's combinational arithmetic right shifter. It uses a valid/ready handshake on both input and output. It resolves one shamt bit per cycle: stage k conditionally shifts by 2**k, zero-filling from the LSB. It is intended for area-constrained datapaths (e.g. a serialized SLL path in a small RV32 core) where a full barrel shifter is too large.

Parameters:
NUM_BITS, 32, data width; must be a power of two and at least 2.
NUM_SHIFT_BITS, $clog2(NUM_BITS), localparam; shamt width and number of shift stages.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
in_val  input  1  operand valid
in_rdy  output  1  block can accept an operand
in  input  NUM_BITS  data to shift
shamt  input  NUM_SHIFT_BITS  shift amount
out_val  output  1  result valid
out_rdy  input  1  consumer accepts result
out  output  NUM_BITS  shifted result

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n is low: state=IDLE, data_reg=0, shamt_reg=0, cnt=0. Outputs: out_val=0, out=0, in_rdy=1.
- States:
  - IDLE: in_rdy=1, out_val=0. On in_val&&in_rdy: data_reg<=in, shamt_reg<=shamt, cnt<=0, go to SHIFT.
  - SHIFT: in_rdy=0, out_val=0. Each cycle: if shamt_reg[cnt], data_reg<=data_reg<<(2**cnt), zero-filled; cnt<=cnt+1. When cnt==NUM_SHIFT_BITS-1, go to DONE.
  - DONE: out_val=1, in_rdy=0. out=data_reg, held stable. On out_rdy, go to IDLE.
- out is wired directly to data_reg. Its value is meaningful only while out_val=1.
- Latency: out_val rises exactly NUM_SHIFT_BITS cycles after the accepting edge (5 for NUM_BITS=32). This holds independent of shamt.
- in_val outside IDLE is ignored; the operand is not captured.
- A new operand can be accepted no earlier than the cycle after the output handshake. Throughput is one result per NUM_SHIFT_BITS+2 cycles minimum.
- Shift arithmetic:
  - Result equals (in << shamt) truncated to NUM_BITS.
  - shamt=0 returns in unchanged.
  - Bits shifted past the MSB are discarded; there is no wrap-around or rotate.
- out_rdy held low in DONE: the block stalls indefinitely, with out and out_val stable.
- rst_n asserted in any state: the operation is aborted immediately, with reset values as above. The operand is lost and no result is produced.
- in_val, shamt and in are sampled only on the accepting edge. Later changes have no effect.

Optional Feature:
Macro DL_LSHIFT_SEQ_EARLY_DONE_EN.
- Defined: early termination.
  - On accept with shamt==0, go directly to DONE; out_val rises 1 cycle after accept.
  - In SHIFT, go to DONE after processing bit cnt when all shamt_reg bits above cnt are 0.
  - Latency = 1 + (index of highest set bit of shamt), range 1..NUM_SHIFT_BITS.
- Undefined: fixed latency of NUM_SHIFT_BITS, as above.
- The result value is identical in both builds.

Decomposition:
- Package dl_shift_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} dl_shift_state_t, shared with future sequential right shifters;
  - the shared power-of-two width check.
- Sub-module dl_lshift_stage: combinational; inputs data, stage index, enable; output data<<(2**index) when enabled, else data unchanged. It is instantiated once and driven by cnt.
- FSM, counter and handshake stay in dl_lshift_seq.

Test Plan:
- Basic shift: in=0x0000_0001, shamt=31 -> out=0x8000_0000; out_val rises 5 cycles after accept.
- Nibble shift: in=0xDEAD_BEEF, shamt=4 -> out=0xEADB_EEF0. Latency is 5; with DL_LSHIFT_SEQ_EARLY_DONE_EN it is 3.
- Zero shift: in=0x1234_5678, shamt=0 -> out=0x1234_5678. Latency is 5; with the macro it is 1.
- Output backpressure: out_rdy held low 10 cycles in DONE -> out and out_val=1 stable throughout, in_rdy=0. A second in_val=1 with in=0xFFFF_FFFF is not captured.
- Mid-operation reset: rst_n pulled low 2 cycles after accept of in=0xFFFF_FFFF, shamt=1, asynchronously (no clock edge required) -> out_val=0, out=0, in_rdy=1. After release, in=0x3, shamt=2 -> out=0xC.
- Back-to-back ops: output handshake for op A, then in_rdy=1 on the next cycle. Op B (in=0x8000_0001, shamt=1) accepted -> out=0x0000_0002; op A's result is not corrupted.
